// File: rtl/xyz_debug_mon_pkg.sv
// Shared constants for the OCI debug monitor memory: jdo field offsets,
// data width and the JTAG read FSM encoding.
package xyz_debug_mon_pkg;

  localparam int DATA_W       = 32;
  localparam int JDO_W        = 38;
  localparam int JDO_RD_BIT   = 34;
  localparam int JDO_ADDR_LSB = 17;
  localparam int JDO_DATA_LSB = 3;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;

endpackage

// File: rtl/xyz_debug_mon_ram.sv
// Single-port monitor RAM with byte enables and an RD_LAT-deep registered
// read pipeline; the read pipeline holds its value when no read is issued.
module xyz_debug_mon_ram
  import xyz_debug_mon_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  re,
  input  logic                  we,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  output logic [DATA_W-1:0]     rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem  [DEPTH];
  logic [DATA_W-1:0] rd_p [RD_LAT];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // read stage p0 loads only on a read so captured data survives idle cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) rd_p[i] <= '0;
    end else begin
      if (re) rd_p[0] <= mem[addr];
      for (int i = 1; i < RD_LAT; i++) rd_p[i] <= rd_p[i-1];
    end
  end

  assign rdata = rd_p[RD_LAT-1];

endmodule

// File: rtl/xyz_nios2_gen2_0_cpu_debug_mon_mem.sv
// OCI monitor memory: JTAG-side address/data registers, read FSM and CPU port
// arbitration. Optional write protection of the ROM region: MONITOR_ROM_PROTECT_EN.
module xyz_nios2_gen2_0_cpu_debug_mon_mem
  import xyz_debug_mon_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int ROM_WORDS = 64,
  parameter int RD_LAT    = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [JDO_W-1:0]    jdo,
  input  logic                take_action_ocimem_a,
  input  logic                take_no_action_ocimem_a,
  input  logic                take_action_ocimem_b,
  input  logic                debugack,
  input  logic [ADDR_W-1:0]   cpu_address,
  input  logic                cpu_read,
  input  logic                cpu_write,
  input  logic [DATA_W-1:0]   cpu_writedata,
  input  logic [DATA_W/8-1:0] cpu_byteenable,
  output logic [DATA_W-1:0]   cpu_readdata,
  output logic                cpu_waitrequest,
  output logic [DATA_W-1:0]   MonDReg,
  output logic                monitor_ready,
  output logic                monitor_error
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]          state;
  logic [1:0]          wait_cnt;
  logic                rd_stream;
  logic [ADDR_W-1:0]   mon_a_reg;

  logic                idle, load_a, rd_start, jtag_wr, jtag_own;
  logic                jtag_wr_ok, cpu_wr_ok;
  logic [ADDR_W-1:0]   jdo_addr;
  logic [DATA_W-1:0]   jdo_data;

  logic [ADDR_W-1:0]   ram_addr;
  logic                ram_re, ram_we;
  logic [DATA_W-1:0]   ram_wdata, ram_rdata;
  logic [DATA_W/8-1:0] ram_be;

  assign jdo_addr = jdo[JDO_ADDR_LSB +: ADDR_W];
  assign jdo_data = jdo[JDO_DATA_LSB +: DATA_W];

  // strobes only count in IDLE; ocimem_a wins if the slave ever overlaps them
  assign idle     = (state == IDLE);
  assign load_a   = idle & take_action_ocimem_a;
  assign rd_start = idle & ((take_action_ocimem_a & jdo[JDO_RD_BIT]) |
                            (take_no_action_ocimem_a & ~take_action_ocimem_a));
  assign jtag_wr  = idle & take_action_ocimem_b & ~take_action_ocimem_a & ~take_no_action_ocimem_a;
  assign jtag_own = rd_start | jtag_wr | (state == RD_WAIT);

  assign cpu_waitrequest = reset_n & jtag_own;

`ifdef MONITOR_ROM_PROTECT_EN
  function automatic logic in_rom(input logic [ADDR_W-1:0] a);
    return {{(32-ADDR_W){1'b0}}, a} < 32'(ROM_WORDS);
  endfunction

  assign jtag_wr_ok = ~in_rom(mon_a_reg);
  assign cpu_wr_ok  = debugack | ~in_rom(cpu_address);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  monitor_error <= 1'b0;
    else if (load_a)               monitor_error <= 1'b0;
    else if (jtag_wr & ~jtag_wr_ok) monitor_error <= 1'b1;
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_DATA_LSB-1:0]};
`else
  assign jtag_wr_ok    = 1'b1;
  assign cpu_wr_ok     = 1'b1;
  assign monitor_error = 1'b0;

  logic unused_ok;
  assign unused_ok = &{1'b0, jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_DATA_LSB-1:0],
                       debugack, (ROM_WORDS != 0)};
`endif

  always_comb begin
    ram_addr  = cpu_address;
    ram_re    = cpu_read;
    ram_we    = cpu_write & cpu_wr_ok;
    ram_wdata = cpu_writedata;
    ram_be    = cpu_byteenable;
    if (jtag_own) begin
      ram_addr  = take_action_ocimem_a ? jdo_addr : mon_a_reg;
      ram_re    = rd_start;
      ram_we    = jtag_wr & jtag_wr_ok;
      ram_wdata = jdo_data;
      ram_be    = '1;
    end
  end

  xyz_debug_mon_ram #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (ram_addr),
    .re      (ram_re),
    .we      (ram_we),
    .wdata   (ram_wdata),
    .be      (ram_be),
    .rdata   (ram_rdata)
  );

  assign cpu_readdata = ram_rdata;

  // RD_WAIT covers the RAM pipeline; CAPTURE samples its settled output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      rd_stream     <= 1'b0;
      mon_a_reg     <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_a) begin
            mon_a_reg     <= jdo_addr;
            monitor_ready <= 1'b0;
          end
          if (rd_start) begin
            state     <= RD_WAIT;
            wait_cnt  <= 2'(RD_LAT-1);
            rd_stream <= ~take_action_ocimem_a;
          end
          if (jtag_wr) begin
            MonDReg   <= jdo_data;
            mon_a_reg <= mon_a_reg + ADDR_ONE;
          end
        end
        RD_WAIT: begin
          if (wait_cnt == 2'd0) state <= CAPTURE;
          else                  wait_cnt <= wait_cnt - 2'd1;
        end
        CAPTURE: begin
          MonDReg       <= ram_rdata;
          monitor_ready <= 1'b1;
          if (rd_stream) mon_a_reg <= mon_a_reg + ADDR_ONE;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
